// File: rtl/lights_fader.sv
// RGB light source that fades each channel toward white or a button-cycled colour code.
// The slew runs at STEP per channel per prescaled tick.
module lights_fader #(
  parameter int CH_W     = 8,
  parameter int STEP     = 1,
  parameter int PRESCALE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sel,
  input  logic              i_button,
  output logic [3*CH_W-1:0] o_light,
  output logic [2:0]        o_colour,
  output logic              o_busy
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0]   STEP_X  = (CH_W + 1)'(STEP);
  localparam logic [CH_W-1:0] STEP_C  = CH_W'(STEP);
  localparam logic [CH_W-1:0] FULL    = '1;

  logic            r_s1, r_s2, r_s3;
  logic [PS_W-1:0] r_ps;
  logic [2:0]      r_colour;
  logic [CH_W-1:0] r_ch [3];

  logic            w_press;
  logic            w_tick;
  logic            w_busy;
  logic            w_up   [3];
  logic [CH_W:0]   w_diff [3];
  logic [CH_W-1:0] w_tgt  [3];
  logic [CH_W-1:0] w_next [3];

  assign w_press = r_s2 & ~r_s3;
  assign w_tick  = (r_ps == PS_LAST);

  // Channel index 2 is red, 1 green, 0 blue, matching the colour code bits.
  always_comb begin
    w_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      w_tgt[c]  = (~i_sel | r_colour[c]) ? FULL : '0;
      w_up[c]   = (w_tgt[c] >= r_ch[c]);
      w_diff[c] = w_up[c] ? ({1'b0, w_tgt[c]} - {1'b0, r_ch[c]})
                          : ({1'b0, r_ch[c]} - {1'b0, w_tgt[c]});
      w_next[c] = r_ch[c];
      if (w_diff[c] <= STEP_X)
        w_next[c] = w_tgt[c];
      else if (w_up[c])
        w_next[c] = r_ch[c] + STEP_C;
      else
        w_next[c] = r_ch[c] - STEP_C;
      if (r_ch[c] != w_tgt[c])
        w_busy = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_ps     <= '0;
      r_colour <= 3'd1;
      for (int c = 0; c < 3; c++)
        r_ch[c] <= FULL;
    end else begin
      r_s1 <= i_button;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_ps <= w_tick ? '0 : r_ps + 1'b1;
      // Codes 0 and 7 are illegal, so any out-of-range value recovers to 1.
      if (w_press)
        r_colour <= (r_colour == 3'd0 || r_colour >= 3'd6) ? 3'd1 : r_colour + 3'd1;
      if (w_tick)
        for (int c = 0; c < 3; c++)
          r_ch[c] <= w_next[c];
    end
  end

  assign o_light  = {r_ch[2], r_ch[1], r_ch[0]};
  assign o_colour = r_colour;
  assign o_busy   = w_busy;

endmodule

// File: tb/tb_lights_fader.sv
// Bench for lights_fader: three instances with different STEP/PRESCALE share the
// same inputs and are compared every cycle against an arithmetic reference model.
module tb_lights_fader;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        button;
  logic [23:0] lt [3];
  logic [2:0]  co [3];
  logic        bz [3];

  int ST [3] = '{1, 16, 1};
  int PR [3] = '{1, 1, 4};

  int ml [3][3];
  int mc [3];
  int me [3];
  int hb [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lights_fader #(.CH_W(8), .STEP(1), .PRESCALE(1)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_button(button),
    .o_light(lt[0]), .o_colour(co[0]), .o_busy(bz[0]));
  lights_fader #(.CH_W(8), .STEP(16), .PRESCALE(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_button(button),
    .o_light(lt[1]), .o_colour(co[1]), .o_busy(bz[1]));
  lights_fader #(.CH_W(8), .STEP(1), .PRESCALE(4)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_button(button),
    .o_light(lt[2]), .o_colour(co[2]), .o_busy(bz[2]));

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) ml[d][c] = 255;
      mc[d] = 1;
      me[d] = 0;
    end
    for (int i = 0; i < 3; i++) hb[i] = 0;
  endtask

  // hb[0..2] hold the button as sampled 1, 2 and 3 edges ago.
  task automatic model_step();
    int t, df;
    bit press;
    if (rst) begin
      model_reset();
      return;
    end
    press = (hb[1] != 0) && (hb[2] == 0);
    for (int d = 0; d < 3; d++) begin
      me[d]++;
      if (me[d] % PR[d] == 0) begin
        for (int c = 0; c < 3; c++) begin
          t  = (!sel || ((mc[d] >> c) & 1) != 0) ? 255 : 0;
          df = t - ml[d][c];
          if (df <= ST[d] && df >= -ST[d]) ml[d][c] = t;
          else if (df > 0) ml[d][c] = ml[d][c] + ST[d];
          else ml[d][c] = ml[d][c] - ST[d];
        end
      end
      if (press) mc[d] = (mc[d] >= 1 && mc[d] <= 5) ? mc[d] + 1 : 1;
    end
    hb[2] = hb[1];
    hb[1] = hb[0];
    hb[0] = int'(button);
  endtask

  function automatic logic [27:0] exp_vec(int d);
    logic busy;
    int   t;
    busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      t = (!sel || ((mc[d] >> c) & 1) != 0) ? 255 : 0;
      if (ml[d][c] != t) busy = 1'b1;
    end
    return {8'(ml[d][2]), 8'(ml[d][1]), 8'(ml[d][0]), 3'(mc[d]), busy};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] want;
    rst = 1'b0; sel = 1'b0; button = 1'b0;
    #1 rst = 1'b1;
    #1 model_reset();
    want = {24'hFFFFFF, 3'b001, 1'b0};
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({lt[d], co[d], bz[d]} !== want) begin
        n_err++;
        $display("FAIL reset_sel0 inst%0d got %h want %h", d, {lt[d], co[d], bz[d]}, want);
      end
    end
    sel = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (bz[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_busy_sel1 inst%0d got %b want 1", d, bz[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fade();
    for (int k = 1; k <= 300; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL fade inst%0d cyc%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
      if (k == 254 || k == 255) begin
        n_vec++;
        if ({lt[0], bz[0]} !== ((k == 255) ? {24'h0000FF, 1'b0} : {24'h0101FF, 1'b1})) begin
          n_err++;
          $display("FAIL fade_end cyc%0d got %h/%b", k, lt[0], bz[0]);
        end
      end
    end
  endtask

  task automatic test_presses();
    int seq [6] = '{2, 3, 4, 5, 6, 1};
    for (int p = 0; p < 6; p++) begin
      button = 1'b1;
      for (int k = 0; k < 6; k++) begin
        cycle();
        if (k == 2) button = 1'b0;
        for (int d = 0; d < 3; d++) begin
          n_vec++;
          if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
            n_err++;
            $display("FAIL press%0d inst%0d k%0d got %h want %h", p, d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
          end
        end
      end
      n_vec++;
      if (co[0] !== 3'(seq[p])) begin
        n_err++;
        $display("FAIL press_seq%0d got %0d want %0d", p, co[0], seq[p]);
      end
    end
    button = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL hold inst%0d k%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
    end
    button = 1'b0;
    n_vec++;
    if (co[1] !== 3'd2) begin
      n_err++;
      $display("FAIL hold_once got %0d want 2", co[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) button = ~button;
      if ($urandom_range(0, 99) == 0) sel = ~sel;
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL random inst%0d k%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
    end
    button = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [27:0] want;
    sel = ~sel;
    for (int k = 0; k < 30; k++) begin
      button = (k >= 5 && k < 8);
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL midfade inst%0d k%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
    end
    #2 rst = 1'b1;
    #1 model_reset();
    want = {24'hFFFFFF, 3'b001, sel};
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if ({lt[d], co[d], bz[d]} !== want) begin
        n_err++;
        $display("FAIL async_rst inst%0d got %h want %h", d, {lt[d], co[d], bz[d]}, want);
      end
    end
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL post_rst inst%0d k%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_prescale_full();
    sel = 1'b1;
    for (int k = 0; k < 1100; k++) cycle();
    sel = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({lt[d], co[d], bz[d]} !== exp_vec(d)) begin
          n_err++;
          $display("FAIL rise inst%0d k%0d got %h want %h", d, k, {lt[d], co[d], bz[d]}, exp_vec(d));
        end
      end
    end
    n_vec++;
    if ({lt[2], bz[2]} !== {24'hFFFFFF, 1'b0}) begin
      n_err++;
      $display("FAIL rise_end got %h/%b want ffffff/0", lt[2], bz[2]);
    end
  endtask

  initial begin
    test_reset();
    test_fade();
    test_presses();
    test_random();
    test_rst_mid();
    test_prescale_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lights_fader.md
# lights_fader

Parametrised successor to the lights selector. It produces a 3-channel RGB light word from either full-scale white (`sel=0`) or a button-cycled colour code (`sel=1`). Unlike the hard-switched selector, the output slews channel-by-channel toward the selected target at a programmable rate, so colour and mode changes fade smoothly. It sits between the button/select inputs and the light driver, and absorbs the colour counter, the code-to-RGB conversion and the output mux.

## Interface
- `CH_W`, 8: bits per colour channel; `light` width is `3*CH_W`.
- `STEP`, 1: maximum change per channel per tick; range 1..2^CH_W-1.
- `PRESCALE`, 1: clock cycles per tick; minimum 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sel` in 1: 0 selects white, 1 selects coded colour. Synchronous to `clk`.
- `button` in 1: raw push-button, asynchronous; synchronised internally.
- `light` out 3*CH_W: registered output, ordered {R, G, B}, with R in the MSBs.
- `colour` out 3: current colour code, ordered {R, G, B} bits.
- `busy` out 1: high while `light` differs from the current target.

## Operation
- **Button path**
  - Two-flop synchroniser (`s1`, `s2`), then a delay flop `s3`.
  - A press is detected when `s2 & ~s3`, i.e. a single pulse per rising edge of `button`. No debounce; each bounce edge counts.
- **Colour counter** (3-bit)
  - Advances by 1 on each press: 1→2→3→4→5→6→1.
  - Codes 0 (black) and 7 (white) are never produced.
  - If the register ever holds 0 or 7, the next press loads 1.
- **Target**
  - `sel=0`: every channel = 2^CH_W-1.
  - `sel=1`: each channel is 2^CH_W-1 if its code bit is set, else 0 (R=`colour[2]`, G=`colour[1]`, B=`colour[0]`).
  - Target is combinational from `sel` and `colour`.
- **Prescaler**
  - Counter runs 0..PRESCALE-1; `tick` is asserted when count == PRESCALE-1, after which the counter wraps to 0.
  - PRESCALE=1 gives a tick every cycle.
- **Slew, per channel independently, on tick only**
  - If |target−cur| ≤ STEP: cur ← target.
  - Else cur ← cur ± STEP toward target.
  - Compute the difference with CH_W+1 bits; never wrap or overshoot.
- **Retargeting:** if `sel` or `colour` changes mid-fade, the target changes immediately and the slew continues from the present `light` value. No restart, no wait.
- **Busy:** `busy` = (`light` != target), combinational from registered state.

## Timing
- **Reset values:**
  - `light` = all ones (white)
  - `colour` = 3'b001
  - prescaler = 0
  - `s1`/`s2`/`s3` = 0
  - `busy` = 0 if `sel=0`, 1 if `sel=1`
- **Reset is asynchronous:** outputs take their reset values without a clock edge. Reset asserted mid-fade abandons the fade. After release, the first tick occurs PRESCALE edges later.
- **Button latency:** if `button` is first sampled high at edge k, then `s2` rises at k+1 and `colour` updates at edge k+2. A held button advances `colour` exactly once.
- **Slew latency:** a target change before edge e first moves `light` at the first tick edge ≥ e. A full-scale transition takes ceil((2^CH_W-1)/STEP) ticks.
- **Simultaneous events:** a press and a tick on the same edge are handled as follows:
  - `colour` updates on that edge.
  - The slew on that edge uses the old target.
  - The new target applies from the next tick.

## Test plan
- Reset with `sel=0`, CH_W=8 → `light`=24'hFFFFFF, `colour`=1, `busy`=0, with no clock edge required.
- `sel` 0→1, `colour`=1, STEP=1, PRESCALE=1 → R and G fall by 1 per cycle to 0 after 255 cycles; B stays FF; `busy` deasserts on cycle 255.
- STEP=16, white→colour 4 (red) → G and B step 255, 239, …, 15, 0: 16 ticks total, no underflow; R stays FF.
- PRESCALE=4, STEP=1 → `light` changes only every 4th edge; 0→FF takes 1020 cycles.
- Six single presses from reset → `colour` = 2,3,4,5,6,1, each 2 edges after `button` is first sampled high. Holding `button` for 50 cycles gives a single increment.
- Press during a fade, then assert `rst` mid-fade → the fade retargets without a jump; under `rst`, `light` goes to FFFFFF and `colour` to 1 asynchronously.
